neuron_act_buffer: RTL and testbench

Downstream stage of the single-neuron core. Sequences repeated neuron evaluations for one output layer by pulsing the neuron's `start` and capturing each 16-bit signed accumulator result when the neuron raises `ready`. Each result passes through ReLU, an arithmetic right shift and unsigned saturation to DW bits, then goes into a small FIFO. The FIFO feeds the next layer through a valid/ack handshake, and the stage never launches a neuron whose result could not be stored.

---
 rtl/nn_pkg.sv | 15 +
 rtl/act_fifo.sv | 71 +++++++
 rtl/neuron_act_buffer.sv | 165 ++++++++++++++++
 tb/tb_neuron_act_buffer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Definitions shared by the single-neuron core and its downstream activation buffer.
// Holds the buffer FSM state encoding and the common datapath widths.
package nn_pkg;

    localparam int ACC_W  = 16;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        PUSH   = 2'd3
    } act_state_t;

endpackage

// File: rtl/act_fifo.sv
// DEPTH x DW synchronous FIFO with occupancy count; head entry is read combinationally.
// Pops on empty are dropped; a push into a full FIFO is accepted only alongside a pop.
module act_fifo #(
    parameter int  DEPTH = 4,
    parameter int  DW    = 8,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic [CW-1:0] count
);

    logic [DW-1:0] mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          push_s;
    logic          pop_s;

    // Qualify the requests against the current occupancy
    always_comb begin
        pop_s  = pop && (count_r != {CW{1'b0}});
        push_s = push && ((count_r != CW'(DEPTH)) || pop_s);
    end

    // Storage array; reset to zero so the head reads zero out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DW{1'b0}};
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
        end else begin
            wr_ptr_r <= push_s ? (wr_ptr_r + PW'(1)) : wr_ptr_r;
            rd_ptr_r <= pop_s  ? (rd_ptr_r + PW'(1)) : rd_ptr_r;
        end
    end

    // Occupancy counter; simultaneous push and pop leave it unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CW{1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/neuron_act_buffer.sv
// Sequences NUM_OUT neuron evaluations, activates each result (ReLU, shift, saturate)
// and queues it for the next layer; a neuron is only launched when its result has a slot.
module neuron_act_buffer
    import nn_pkg::*;
#(
    parameter int  NUM_OUT = 10,
    parameter int  DW      = DATA_W,
    parameter int  AW      = ACC_W,
    parameter int  SHIFT   = 4,
    parameter int  DEPTH   = 4,
    localparam int IW      = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    output logic          neuron_start,
    input  logic          neuron_ready,
    input  logic [AW-1:0] neuron_out,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ack,
    output logic          busy,
    output logic          done,
    output logic [IW-1:0] index
);

    localparam int CW = $clog2(DEPTH + 1);

    act_state_t    state_r;
    act_state_t    state_next_s;
    logic          neuron_start_r;
    logic          start_next_s;
    logic          done_r;
    logic          done_next_s;
    logic          busy_r;
    logic          busy_next_s;
    logic          ready_q_r;
    logic          capture_s;
    logic          push_s;
    logic          inflight_s;
    logic          space_s;
    logic [IW-1:0] index_r;
    logic [IW-1:0] index_next_s;
    logic [AW-1:0] acc_r;
    logic [CW-1:0] fifo_count_s;
    logic [CW:0]   occupancy_s;

    function automatic logic [DW-1:0] activate(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        logic [AW-1:0] s;
        r = a[AW-1] ? {AW{1'b0}} : a;
        s = r >> SHIFT;
        if ((s >> DW) != {AW{1'b0}}) begin
            activate = {DW{1'b1}};
        end else begin
            activate = s[DW-1:0];
        end
    endfunction

    // Slot reservation: FIFO occupancy plus the neuron result still owed
    always_comb begin
        inflight_s  = (state_r == WAIT) || (state_r == PUSH);
        occupancy_s = {1'b0, fifo_count_s} + {{CW{1'b0}}, inflight_s};
        space_s     = occupancy_s < (CW + 1)'(DEPTH);
    end

    // Next-state and next-output logic for the launch/capture sequencer
    always_comb begin
        state_next_s = state_r;
        start_next_s = 1'b0;
        done_next_s  = 1'b0;
        capture_s    = 1'b0;
        push_s       = 1'b0;
        index_next_s = index_r;
        case (state_r)
            IDLE: begin
                if (run && !busy_r) begin
                    index_next_s = {IW{1'b0}};
                    state_next_s = LAUNCH;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LAUNCH: begin
                if (space_s) begin
                    start_next_s = 1'b1;
                    state_next_s = WAIT;
                end else begin
                    state_next_s = LAUNCH;
                end
            end
            WAIT: begin
                if (neuron_ready && !ready_q_r) begin
                    capture_s    = 1'b1;
                    state_next_s = PUSH;
                end else begin
                    state_next_s = WAIT;
                end
            end
            PUSH: begin
                push_s = 1'b1;
                if (index_r == IW'(NUM_OUT - 1)) begin
                    done_next_s  = 1'b1;
                    state_next_s = IDLE;
                end else begin
                    index_next_s = index_r + IW'(1);
                    state_next_s = LAUNCH;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
        // busy stays up through the done cycle so it drops the cycle after done
        busy_next_s = (state_next_s != IDLE) || done_next_s;
    end

    // FSM state and registered control outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r        <= IDLE;
            neuron_start_r <= 1'b0;
            done_r         <= 1'b0;
            busy_r         <= 1'b0;
            index_r        <= {IW{1'b0}};
        end else begin
            state_r        <= state_next_s;
            neuron_start_r <= start_next_s;
            done_r         <= done_next_s;
            busy_r         <= busy_next_s;
            index_r        <= index_next_s;
        end
    end

    // Ready edge detector and accumulator capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q_r <= 1'b0;
            acc_r     <= {AW{1'b0}};
        end else begin
            ready_q_r <= neuron_ready;
            acc_r     <= capture_s ? neuron_out : acc_r;
        end
    end

    act_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .push      (push_s),
        .push_data (activate(acc_r)),
        .pop       (out_ack),
        .head      (out_data),
        .count     (fifo_count_s)
    );

    assign out_valid    = (fifo_count_s != {CW{1'b0}});
    assign neuron_start = neuron_start_r;
    assign done         = done_r;
    assign busy         = busy_r;
    assign index        = index_r;

endmodule

// File: tb/tb_neuron_act_buffer.sv
// Randomised bench for neuron_act_buffer: a behavioural neuron answers each start pulse,
// and every handed-off value is compared with a queue of expected activations.
module tb_neuron_act_buffer;

    localparam int NUM_OUT = 10;
    localparam int DW      = 8;
    localparam int AW      = 16;
    localparam int SHIFT   = 4;
    localparam int DEPTH   = 4;
    localparam int IW      = $clog2(NUM_OUT);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          run = 1'b0;
    logic          neuron_ready = 1'b0;
    logic [AW-1:0] neuron_out = '0;
    logic          out_ack = 1'b0;
    logic          neuron_start;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          busy;
    logic          done;
    logic [IW-1:0] index;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int served = 0;
    int done_cnt = 0;
    int layer_base = 0;
    int l_s0 = 0;
    int l_d0 = 0;
    int ack_mode = 1;
    int lat_max = 3;
    int hold_min = 1;
    int hold_max = 3;
    int exp_q[$];
    int got_q[$];
    logic [AW-1:0] dir_q[$];

    neuron_act_buffer #(
        .NUM_OUT (NUM_OUT),
        .DW      (DW),
        .AW      (AW),
        .SHIFT   (SHIFT),
        .DEPTH   (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .neuron_start (neuron_start),
        .neuron_ready (neuron_ready),
        .neuron_out   (neuron_out),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ack      (out_ack),
        .busy         (busy),
        .done         (done),
        .index        (index)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference activation written directly from the arithmetic definition
    function automatic int ref_act(input logic [AW-1:0] v);
        int s;
        s = $signed(v);
        if (s < 0) return 0;
        s = s / (1 << SHIFT);
        return (s > 255) ? 255 : s;
    endfunction

    // Start-pulse and done-pulse bookkeeping
    initial begin
        forever begin
            @(negedge clk);
            if (neuron_start === 1'b1) begin
                check_val("start_index", index, start_cnt - layer_base);
                start_cnt++;
            end
            if (done === 1'b1) done_cnt++;
        end
    end

    // Behavioural neuron: one result per start, random latency and ready hold time
    initial begin : nrn_model
        int lat;
        int hold;
        int kind;
        logic [AW-1:0] v;
        forever begin
            @(posedge clk);
            #2;
            if (served < start_cnt) begin
                lat = $urandom_range(0, lat_max);
                repeat (lat) begin @(posedge clk); #2; end
                if (dir_q.size() != 0) begin
                    v = dir_q.pop_front();
                end else begin
                    kind = $urandom_range(0, 3);
                    case (kind)
                        0:       v = 16'h8000 | 16'($urandom_range(0, 32767));
                        1:       v = 16'($urandom_range(0, 4095));
                        2:       v = 16'($urandom_range(4096, 32767));
                        default: v = 16'($urandom);
                    endcase
                end
                neuron_out   = v;
                neuron_ready = 1'b1;
                exp_q.push_back(ref_act(v));
                served++;
                hold = $urandom_range(hold_min, hold_max);
                repeat (hold) begin @(posedge clk); #2; end
                neuron_ready = 1'b0;
            end
        end
    end

    // Consumer: choose ack for the coming edge, then score any handshake it completes
    initial begin
        forever begin
            @(negedge clk);
            case (ack_mode)
                0:       out_ack = 1'b0;
                1:       out_ack = 1'b1;
                default: out_ack = ($urandom_range(0, 2) != 0);
            endcase
            if (rst && out_valid && out_ack) begin
                check_val("pop_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    check_val("out_data", out_data, exp_q.pop_front());
                end
                got_q.push_back(int'(out_data));
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_start"}, neuron_start, 0);
        check_val({tag, "_valid"}, out_valid, 0);
        check_val({tag, "_data"}, out_data, 0);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_done"}, done, 0);
        check_val({tag, "_index"}, index, 0);
    endtask

    task automatic start_layer(input string tag);
        l_s0 = start_cnt;
        l_d0 = done_cnt;
        layer_base = start_cnt;
        got_q.delete();
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        check_val({tag, "_busy_rise"}, busy, 1);
    endtask

    task automatic finish_layer(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
        check_val({tag, "_done_seen"}, n < 3000, 1);
        check_val({tag, "_busy_at_done"}, busy, 1);
        @(negedge clk);
        check_val({tag, "_done_pulse"}, done, 0);
        check_val({tag, "_busy_fall"}, busy, 0);
        n = 0;
        while ((exp_q.size() != 0 || served != start_cnt || neuron_ready) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check_val({tag, "_drained"}, exp_q.size(), 0);
        check_val({tag, "_valid_empty"}, out_valid, 0);
        check_val({tag, "_starts"}, start_cnt - l_s0, NUM_OUT);
        check_val({tag, "_dones"}, done_cnt - l_d0, 1);
        check_val({tag, "_pops"}, got_q.size(), NUM_OUT);
    endtask

    initial begin
        int n;
        int seen;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Free-flowing output with three directed results first
        dir_q.push_back(16'h0345);
        dir_q.push_back(16'h7FFF);
        dir_q.push_back(16'hFF00);
        ack_mode = 1; lat_max = 2; hold_min = 1; hold_max = 2;
        start_layer("flow");
        finish_layer("flow");
        check_val("flow_v0", got_q[0], 32'h34);
        check_val("flow_v1", got_q[1], 32'hFF);
        check_val("flow_v2", got_q[2], 32'h00);

        // Backpressure: no acks, launches stop once every slot is claimed
        ack_mode = 0; lat_max = 3; hold_min = 1; hold_max = 3;
        start_layer("bp");
        repeat (150) @(negedge clk);
        check_val("bp_starts_stalled", start_cnt - l_s0, DEPTH);
        check_val("bp_busy", busy, 1);
        check_val("bp_valid", out_valid, 1);
        check_val("bp_index", index, DEPTH);
        ack_mode = 1;
        finish_layer("bp");

        // Neuron holds ready for five cycles on every result
        ack_mode = 2; hold_min = 5; hold_max = 5;
        start_layer("hold");
        finish_layer("hold");

        // run pulse while waiting on the second neuron
        hold_min = 1; hold_max = 3;
        start_layer("rwb");
        n = 0; seen = 0;
        while (seen < 2 && n < 500) begin
            if (neuron_start === 1'b1) seen++;
            if (seen < 2) begin @(negedge clk); n++; end
        end
        check_val("rwb_second_start", seen, 2);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        check_val("rwb_index", index, 1);
        check_val("rwb_no_extra_start", neuron_start, 0);
        finish_layer("rwb");

        // Random layers exercise pointer wrap and push/pop overlap
        for (int k = 0; k < 3; k++) begin
            ack_mode = 2; hold_min = 1; hold_max = 5; lat_max = 3;
            start_layer($sformatf("rand%0d", k));
            finish_layer($sformatf("rand%0d", k));
        end

        // Reset while waiting on the third neuron with two entries queued
        ack_mode = 0; hold_min = 1; hold_max = 2;
        start_layer("rstmid");
        n = 0; seen = 0;
        while (seen < 3 && n < 500) begin
            if (neuron_start === 1'b1) seen++;
            if (seen < 3) begin @(negedge clk); n++; end
        end
        check_val("rstmid_third_start", seen, 3);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_vals("rstmid");
        rst = 1'b1;
        n = 0;
        while ((served != start_cnt || neuron_ready) && n < 200) begin @(negedge clk); n++; end
        repeat (4) @(negedge clk);
        check_val("rstmid_model_idle", n < 200, 1);
        check_val("rstmid_edge_ignored", out_valid, 0);
        check_val("rstmid_idle", busy, 0);
        exp_q.delete();

        ack_mode = 1;
        start_layer("post");
        finish_layer("post");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
